nmi_apb_bridge: RTL and testbench
=================================

Name: nmi_apb_bridge

Overview:
- NMI responder that converts each accepted NMI transfer into exactly one APB3/APB4 transfer and returns the APB result as a single-cycle NMI ready pulse.
- Sits downstream of the system bus on the APB-bound NMI port, in front of the APB peripheral decoder and flash controller.
- Adds a bounded wait-state timeout so that a hung peripheral cannot stall the core or the DMA indefinitely.

Parameters:
- ADDR_WIDTH, 32: NMI/APB address width.
- DATA_WIDTH, 32: data width. Must be 32; the strobe width is DATA_WIDTH/8.
- TIMEOUT, 255: maximum ACCESS cycles without pready. 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: rdata value returned on a read that sees a timeout or pslverr.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. Synchronous, active-high.
- nmi_valid_i, in, 1: request valid.
- nmi_addr_i, in, ADDR_WIDTH: request address.
- nmi_wdata_i, in, DATA_WIDTH: write data.
- nmi_wstrb_i, in, 4: byte strobes. 0 means read; nonzero means write.
- nmi_ready_o, out, 1: one-cycle completion pulse.
- nmi_rdata_o, out, DATA_WIDTH: read data, valid while nmi_ready_o is high.
- apb_paddr_o, out, ADDR_WIDTH: APB address.
- apb_psel_o, out, 1: APB select.
- apb_penable_o, out, 1: APB enable.
- apb_pwrite_o, out, 1: APB write.
- apb_pwdata_o, out, DATA_WIDTH: APB write data.
- apb_pstrb_o, out, 4: APB write strobes.
- apb_prdata_i, in, DATA_WIDTH: APB read data.
- apb_pready_i, in, 1: APB ready.
- apb_pslverr_i, in, 1: APB slave error.
- err_o, out, 1: one-cycle pulse on timeout or pslverr.

Behaviour:
- Reset: state IDLE; every output is 0, including paddr, pwdata, pstrb and rdata. rst_i overrides all other inputs on the same edge.
  - Reset mid-transfer drops psel/penable on the next edge with no completion.
  - The master must re-issue the request.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - When nmi_valid_i=1, latch addr, wdata and wstrb; pwrite = (wstrb != 0).
  - Go to SETUP. The NMI fields are never sampled again for this transfer.
- SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1. The timeout counter increments each cycle.
  - If apb_pready_i=1: capture prdata, or ERR_DATA for a read when pslverr=1. Pulse err_o if pslverr=1. Go to RESP.
  - Else, if TIMEOUT!=0 and the counter reaches TIMEOUT: drop psel/penable, capture ERR_DATA for a read, pulse err_o, go to RESP.
- RESP:
  - nmi_ready_o=1 for exactly one cycle only if nmi_valid_i is still 1.
  - If nmi_valid_i=0 (the master was pre-empted or withdrew), the response is silently discarded.
  - Always return to IDLE. Requests are never accepted in RESP; this guarantees at least one idle cycle between back-to-back transfers.
- Latency from accept edge to ready: 3 cycles at zero wait states; +1 per APB wait state.
- nmi_rdata_o:
  - Registered; holds the captured value during RESP and is 0 otherwise.
  - Writes return 0.
  - An errored write completes normally with rdata=0 and err_o pulsed.
- APB outputs: paddr, pwdata, pstrb and pwrite are stable from SETUP through the end of ACCESS. pstrb=0 for reads.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Clears on entry to SETUP and saturates; it never wraps.
  - pready and timeout in the same cycle: pready wins, with no timeout error.
- Requests are serialised: no pipelining and no outstanding transfers.

Decomposition:
- Package nmi_apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the default ERR_DATA constant;
  - the width helpers for the strobe and the counter.
- No sub-module is required. The timeout counter stays inline.

Test Plan:
- Zero-wait read, addr 0x1000_0004, prdata 0x1234_5678, pready=1 in the first ACCESS cycle:
  - psel rises at accept+1 and penable at accept+2.
  - nmi_ready pulses at accept+3 with rdata=0x1234_5678, then drops to 0.
- Write, wstrb=4'b0011, wdata 0xA5A5_0F0F, 2 APB wait states:
  - pwrite=1 and pstrb=0011 are held stable throughout.
  - Ready arrives at accept+5 with rdata=0 and no err_o.
- Timeout, TIMEOUT=4, pready never asserted on a read:
  - psel/penable drop after 4 ACCESS cycles.
  - err_o pulses once; ready carries rdata=0xDEAD_BEEF.
- pslverr=1 with pready on a read:
  - rdata=0xDEAD_BEEF and err_o pulses in the same cycle pready is seen.
  - The next request proceeds normally.
- Withdrawal and back-to-back:
  - Drop nmi_valid during ACCESS: the APB transfer completes, no nmi_ready is issued, and the bridge returns to IDLE.
  - Back-to-back requests show exactly one idle cycle between the ready pulse and the next psel.
- Reset mid-transfer:
  - Assert rst_i for 1 cycle in ACCESS: all outputs are 0 on the next edge.
  - A new read afterwards completes with the correct data.

Source files
------------

// File: rtl/nmi_apb_pkg.sv
// Shared types and constants for the NMI-to-APB bridge.
// Holds the FSM encoding, the error data word and the width helpers.
package nmi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // Keeps at least one counter bit so a zero timeout still elaborates.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/nmi_apb_bridge.sv
// NMI responder that turns each accepted request into one APB transfer.
// A bounded ACCESS timeout keeps a hung peripheral from stalling the bus.
module nmi_apb_bridge
  import nmi_apb_pkg::*;
#(
  parameter int                        ADDR_WIDTH = 32,
  parameter int                        DATA_WIDTH = 32,
  parameter int                        TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0]     ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         nmi_valid_i,
  input  logic [ADDR_WIDTH-1:0]        nmi_addr_i,
  input  logic [DATA_WIDTH-1:0]        nmi_wdata_i,
  input  logic [strb_width(DATA_WIDTH)-1:0] nmi_wstrb_i,
  output logic                         nmi_ready_o,
  output logic [DATA_WIDTH-1:0]        nmi_rdata_o,
  output logic [ADDR_WIDTH-1:0]        apb_paddr_o,
  output logic                         apb_psel_o,
  output logic                         apb_penable_o,
  output logic                         apb_pwrite_o,
  output logic [DATA_WIDTH-1:0]        apb_pwdata_o,
  output logic [strb_width(DATA_WIDTH)-1:0] apb_pstrb_o,
  input  logic [DATA_WIDTH-1:0]        apb_prdata_i,
  input  logic                         apb_pready_i,
  input  logic                         apb_pslverr_i,
  output logic                         err_o
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW:0] TO_LIM = TIMEOUT[CW:0];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [CW:0] cnt_inc;
  logic        tmo_hit;
  logic        psel;
  logic        penable;
  logic        ready;
  logic        err;

  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign tmo_hit = (TIMEOUT != 0) && (cnt_inc >= TO_LIM);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    pwrite_d = pwrite_q;
    cnt_d    = cnt_q;
    rdata_d  = '0;
    psel     = 1'b0;
    penable  = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nmi_valid_i) begin
          addr_d   = nmi_addr_i;
          wdata_d  = nmi_wdata_i;
          strb_d   = nmi_wstrb_i;
          pwrite_d = |nmi_wstrb_i;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (!(&cnt_q)) cnt_d = cnt_inc[CW-1:0];
        // pready has priority over a timeout landing on the same cycle
        if (apb_pready_i) begin
          if (!pwrite_q)
            rdata_d = apb_pslverr_i ? ERR_DATA : apb_prdata_i;
          err     = apb_pslverr_i;
          state_d = RESP;
        end else if (tmo_hit) begin
          if (!pwrite_q) rdata_d = ERR_DATA;
          err     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ready   = nmi_valid_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign nmi_ready_o   = ready;
  assign nmi_rdata_o   = rdata_q;
  assign apb_paddr_o   = addr_q;
  assign apb_psel_o    = psel;
  assign apb_penable_o = penable;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = wdata_q;
  assign apb_pstrb_o   = strb_q;
  assign err_o         = err;

endmodule

// File: tb/tb_nmi_apb_bridge.sv
// Directed plus randomized bench for nmi_apb_bridge with TIMEOUT=4.
// Expected timing and data come from the transfer-level latency rules.
module tb_nmi_apb_bridge;

  localparam int TO = 4;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nmi_apb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TO),
    .ERR_DATA(ERRW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .nmi_valid_i(valid),
    .nmi_addr_i(addr),
    .nmi_wdata_i(wdata),
    .nmi_wstrb_i(wstrb),
    .nmi_ready_o(ready),
    .nmi_rdata_o(rdata),
    .apb_paddr_o(paddr),
    .apb_psel_o(psel),
    .apb_penable_o(penable),
    .apb_pwrite_o(pwrite),
    .apb_pwdata_o(pwdata),
    .apb_pstrb_o(pstrb),
    .apb_prdata_i(prdata),
    .apb_pready_i(pready),
    .apb_pslverr_i(pslverr),
    .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".psel"}, {31'd0, psel}, 32'd0);
    chk({tag, ".penable"}, {31'd0, penable}, 32'd0);
    chk({tag, ".pwrite"}, {31'd0, pwrite}, 32'd0);
    chk({tag, ".ready"}, {31'd0, ready}, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".paddr"}, paddr, 32'd0);
    chk({tag, ".pwdata"}, pwdata, 32'd0);
    chk({tag, ".pstrb"}, {28'd0, pstrb}, 32'd0);
    chk({tag, ".rdata"}, rdata, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid   = 1'b0;
      addr    = $urandom;
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
      @(negedge clk);
      chk("idle.psel", {31'd0, psel}, 32'd0);
      chk("idle.ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // One transfer: cycle 0 is the accept cycle, ready is due in cycle r.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd_val,
                      input int waits, input bit slverr, input int wd_cyc);
    bit          is_rd;
    bit          tmo;
    bit          err_exp;
    int          r;
    logic [31:0] rexp;
    is_rd   = (st == 4'd0);
    tmo     = (waits >= TO);
    r       = tmo ? 2 + TO : 3 + waits;
    err_exp = tmo || slverr;
    rexp    = !is_rd ? 32'd0 : (err_exp ? ERRW : rd_val);
    for (int c = 0; c <= r; c++) begin
      valid   = !(wd_cyc >= 0 && c >= wd_cyc);
      addr    = (c == 0) ? a : $urandom;
      wdata   = (c == 0) ? wd : $urandom;
      wstrb   = (c == 0) ? st : 4'($urandom);
      pready  = (c >= 2) && !tmo && (c - 2 == waits);
      pslverr = pready ? slverr : 1'b0;
      prdata  = pready ? rd_val : $urandom;
      @(negedge clk);
      if (c == 0) begin
        chk("accept.psel", {31'd0, psel}, 32'd0);
        chk("accept.ready", {31'd0, ready}, 32'd0);
      end else if (c < r) begin
        chk("psel", {31'd0, psel}, 32'd1);
        chk("penable", {31'd0, penable}, {31'd0, c >= 2});
        chk("paddr", paddr, a);
        chk("pwrite", {31'd0, pwrite}, {31'd0, !is_rd});
        chk("pstrb", {28'd0, pstrb}, {28'd0, st});
        if (!is_rd) chk("pwdata", pwdata, wd);
        chk("err", {31'd0, err}, {31'd0, err_exp && c == r - 1});
        chk("ready_early", {31'd0, ready}, 32'd0);
      end else begin
        chk("resp.psel", {31'd0, psel}, 32'd0);
        chk("resp.ready", {31'd0, ready}, {31'd0, valid});
        chk("resp.rdata", rdata, rexp);
        chk("resp.err", {31'd0, err}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b1;
    addr    = 32'hFFFF_FFFF;
    wdata   = 32'hFFFF_FFFF;
    wstrb   = 4'hF;
    prdata  = 32'hFFFF_FFFF;
    pready  = 1'b1;
    pslverr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    xfer(32'h1000_0004, 32'h0, 4'b0000, 32'h1234_5678, 0, 1'b0, -1);
    idle(2);
    xfer(32'h2000_0010, 32'hA5A5_0F0F, 4'b0011, 32'h0, 2, 1'b0, -1);
    idle(1);
    xfer(32'h3000_0000, 32'h0, 4'b0000, 32'h5555_AAAA, 10, 1'b0, -1);
    idle(1);
    xfer(32'h3000_0008, 32'h0, 4'b0000, 32'h0BAD_F00D, TO - 1, 1'b0, -1);
    idle(1);
    xfer(32'h4000_0000, 32'h0, 4'b0000, 32'h1111_2222, 0, 1'b1, -1);
    xfer(32'h4000_0004, 32'h0, 4'b0000, 32'h3333_4444, 1, 1'b0, -1);
    xfer(32'h4000_0008, 32'hCAFE_0001, 4'b1111, 32'h0, 1, 1'b1, -1);
    xfer(32'h4000_000C, 32'hCAFE_0002, 4'b1000, 32'h0, 9, 1'b0, -1);
    xfer(32'h5000_0000, 32'h0, 4'b0000, 32'h7777_8888, 2, 1'b0, 3);
    xfer(32'h5000_0004, 32'h0, 4'b0000, 32'h9999_0000, 0, 1'b0, -1);
    xfer(32'h5000_0008, 32'h0, 4'b0000, 32'h9999_0001, 0, 1'b0, -1);

    valid   = 1'b1;
    addr    = 32'h6000_0000;
    wdata   = 32'h0;
    wstrb   = 4'b0000;
    pready  = 1'b0;
    pslverr = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid.penable", {31'd0, penable}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    idle(1);
    xfer(32'h6000_0004, 32'h0, 4'b0000, 32'hFACE_B00C, 1, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] st;
      int         w;
      bit         se;
      int         wdc;
      st  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      w   = $urandom_range(0, 6);
      se  = ($urandom_range(0, 3) == 0);
      wdc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : -1;
      xfer($urandom, $urandom, st, $urandom, w, se, wdc);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
